vga_char_buffer: RTL and testbench



---
 rtl/vga_char_buffer.sv | 190 +++++++++++++++++++
 tb/tb_vga_char_buffer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_char_buffer.sv
// vga_char_buffer: 3x12 text-cell store for the VGA text path.
// Takes a terminal-style character stream (cursor, CR/LF/BS/FF, wrap)
// plus a random-access direct-write port. Presents the cells row-major
// on char_flat (cell k at [8k+7:8k]).
// Ports: clk, rst (sync, active high); in_valid/in_ready/in_char stream;
//   dw_en/dw_addr/dw_data direct write; char_flat; cursor_row/col; busy.
// Option: define VGA_CHAR_BUF_AUTOSCROLL_EN to scroll the screen up on a
//   last-row wrap or LF; otherwise the cursor wraps to (0,0).
module vga_char_buffer #(
    parameter int          COLS  = 12,
    parameter int          ROWS  = 3,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_char,
    input  logic                       dw_en,
    input  logic [5:0]                 dw_addr,
    input  logic [7:0]                 dw_data,
    output logic [ROWS*COLS*8-1:0]     char_flat,
    output logic [1:0]                 cursor_row,
    output logic [3:0]                 cursor_col,
    output logic                       busy
);

    localparam int         NCELL    = ROWS * COLS;
    localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);
    localparam logic [3:0] LAST_COL = 4'(COLS - 1);
    localparam logic [5:0] NCELL6   = 6'(NCELL);

    typedef enum logic [1:0] {
        ST_IDLE,
`ifdef VGA_CHAR_BUF_AUTOSCROLL_EN
        ST_SCROLL,
`endif
        ST_CLEAR
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  row_q, row_d;
    logic [3:0]  col_q, col_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  cell_q [NCELL];
    logic [7:0]  cell_d [NCELL];

    logic        wr_en;
    logic [5:0]  wr_idx;
    logic [7:0]  wr_data;
    logic [5:0]  cur_idx;
    logic        lf_req;

    logic        is_print, is_lf, is_cr, is_bs, is_ff;

    assign is_print = (in_char >= 8'h20) && (in_char <= 8'h7E);
    assign is_lf    = (in_char == 8'h0A);
    assign is_cr    = (in_char == 8'h0D);
    assign is_bs    = (in_char == 8'h08);
    assign is_ff    = (in_char == 8'h0C);

    assign cur_idx  = 6'(row_q) * 6'(COLS) + 6'(col_q);

    // in_ready is a pure function of state, no path from in_valid.
    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = ~in_ready;
    assign cursor_row = row_q;
    assign cursor_col = col_q;

    for (genvar k = 0; k < NCELL; k++) begin : g_flat
        assign char_flat[k*8 +: 8] = cell_q[k];
    end

    // Next-state, cursor and stream write decode.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_idx  = cur_idx;
        wr_data = in_char;
        lf_req  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    unique case (1'b1)
                        is_print: begin
                            wr_en = 1'b1;
                            if (col_q != LAST_COL) begin
                                col_d = col_q + 4'd1;
                            end else begin
                                lf_req = 1'b1;
                            end
                        end
                        is_lf: lf_req = 1'b1;
                        is_cr: col_d = '0;
                        is_bs: begin
                            // No wrap back to the previous row.
                            if (col_q != 4'd0) begin
                                col_d   = col_q - 4'd1;
                                wr_en   = 1'b1;
                                wr_idx  = cur_idx - 6'd1;
                                wr_data = BLANK;
                            end
                        end
                        is_ff: begin
                            row_d   = '0;
                            col_d   = '0;
                            cnt_d   = '0;
                            state_d = ST_CLEAR;
                        end
                        default: ;
                    endcase
                end
                if (lf_req) begin
                    col_d = '0;
                    if (row_q != LAST_ROW) begin
                        row_d = row_q + 2'd1;
                    end else begin
`ifdef VGA_CHAR_BUF_AUTOSCROLL_EN
                        row_d   = LAST_ROW;
                        cnt_d   = '0;
                        state_d = ST_SCROLL;
`else
                        row_d   = '0;
`endif
                    end
                end
            end
`ifdef VGA_CHAR_BUF_AUTOSCROLL_EN
            ST_SCROLL: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == LAST_ROW) state_d = ST_IDLE;
            end
`endif
            ST_CLEAR: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == LAST_ROW) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Cell array next value: one row per cycle while busy.
    always_comb begin
        cell_d = cell_q;
        unique case (state_q)
            ST_IDLE: begin
                if (dw_en && (dw_addr < NCELL6)) cell_d[dw_addr] = dw_data;
                // Applied last so the stream wins a same-cell collision.
                if (wr_en) cell_d[wr_idx] = wr_data;
            end
`ifdef VGA_CHAR_BUF_AUTOSCROLL_EN
            ST_SCROLL: begin
                // Rows 0..ROWS-2 take the row below; last pass blanks the bottom.
                for (int k = 0; k < NCELL; k++) begin
                    if (k / COLS == int'(cnt_q)) begin
                        cell_d[k] = (cnt_q == LAST_ROW) ? BLANK
                                  : cell_q[(k + COLS) % NCELL];
                    end
                end
            end
`endif
            ST_CLEAR: begin
                for (int k = 0; k < NCELL; k++) begin
                    if (k / COLS == int'(cnt_q)) cell_d[k] = BLANK;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < NCELL; k++) cell_q[k] <= BLANK;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < NCELL; k++) cell_q[k] <= cell_d[k];
        end
    end

endmodule

// File: tb/tb_vga_char_buffer.sv
// tb_vga_char_buffer: directed scoreboard bench for vga_char_buffer.
// Stimulus pushes hand-computed screen states; a negedge monitor checks them.
module tb_vga_char_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_char;
    logic         dw_en;
    logic [5:0]   dw_addr;
    logic [7:0]   dw_data;
    logic [287:0] char_flat;
    logic [1:0]   cursor_row;
    logic [3:0]   cursor_col;
    logic         busy;

    always #5 clk = ~clk;

    vga_char_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .dw_en      (dw_en),
        .dw_addr    (dw_addr),
        .dw_data    (dw_data),
        .char_flat  (char_flat),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    typedef struct {
        string        name;
        logic [287:0] flat;
        logic [1:0]   row;
        logic [3:0]   col;
        logic         rdy;
        logic         bsy;
    } rec_t;

    rec_t        sb[$];
    rec_t        mon_r;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [7:0]  exp_cells [36];
    logic [1:0]  exp_row;
    logic [3:0]  exp_col;
    logic        exp_rdy;
    logic        exp_busy;

    function automatic logic [287:0] pack_exp();
        logic [287:0] f;
        for (int k = 0; k < 36; k++) f[k*8 +: 8] = exp_cells[k];
        return f;
    endfunction

    task automatic push(input string name);
        rec_t r;
        r.name = name;
        r.flat = pack_exp();
        r.row  = exp_row;
        r.col  = exp_col;
        r.rdy  = exp_rdy;
        r.bsy  = exp_busy;
        sb.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 36; k++) exp_cells[k] = 8'h20;
        exp_row  = 2'd0;
        exp_col  = 4'd0;
        exp_rdy  = 1'b1;
        exp_busy = 1'b0;
    endtask

    task automatic do_reset(input string name);
        rst      = 1'b1;
        in_valid = 1'b0;
        dw_en    = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        push(name);
    endtask

    task automatic send(input logic [7:0] c);
        in_valid = 1'b1;
        in_char  = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic dwrite(input logic [5:0] a, input logic [7:0] d);
        dw_en   = 1'b1;
        dw_addr = a;
        dw_data = d;
        tick();
        dw_en = 1'b0;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_r = sb.pop_front();
            n_tests++;
            if (char_flat !== mon_r.flat || cursor_row !== mon_r.row ||
                cursor_col !== mon_r.col || in_ready !== mon_r.rdy ||
                busy !== mon_r.bsy) begin
                n_fail++;
                $display("FAIL %s: got flat=%h row=%0d col=%0d rdy=%b busy=%b",
                         mon_r.name, char_flat, cursor_row, cursor_col,
                         in_ready, busy);
                $display("  %s expected flat=%h row=%0d col=%0d rdy=%b busy=%b",
                         mon_r.name, mon_r.flat, mon_r.row, mon_r.col,
                         mon_r.rdy, mon_r.bsy);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_char  = 8'h00;
        dw_en    = 1'b0;
        dw_addr  = 6'd0;
        dw_data  = 8'h00;
        model_reset();

        do_reset("reset");

        // "AB", ignored control, CR
        send(8'h41); exp_cells[0] = 8'h41; exp_col = 4'd1; push("ab_a");
        send(8'h42); exp_cells[1] = 8'h42; exp_col = 4'd2; push("ab_b");
        send(8'h01); push("ctrl_ignored");
        send(8'h0D); exp_col = 4'd0; push("cr");

        // 36 x 'X' then 'Y'
        do_reset("rst_fill");
        for (int i = 0; i < 36; i++) begin
            send(8'h58);
            exp_cells[i] = 8'h58;
            if (i < 35) begin
                exp_row = 2'((i + 1) / 12);
                exp_col = 4'((i + 1) % 12);
            end else begin
`ifdef VGA_CHAR_BUF_AUTOSCROLL_EN
                exp_row  = 2'd2;
                exp_col  = 4'd0;
                exp_rdy  = 1'b0;
                exp_busy = 1'b1;
`else
                exp_row  = 2'd0;
                exp_col  = 4'd0;
`endif
            end
            push("fill_x");
        end
`ifdef VGA_CHAR_BUF_AUTOSCROLL_EN
        in_valid = 1'b1;
        in_char  = 8'h59;
        tick(); push("scroll_c1");
        tick(); push("scroll_c2");
        tick();
        for (int k = 24; k < 36; k++) exp_cells[k] = 8'h20;
        exp_rdy = 1'b1; exp_busy = 1'b0;
        push("scroll_done");
        tick();
        in_valid = 1'b0;
        exp_cells[24] = 8'h59; exp_col = 4'd1;
        push("y_after_scroll");
        // LF on last row moves distinct rows up
        send(8'h0A);
        exp_col = 4'd0; exp_rdy = 1'b0; exp_busy = 1'b1;
        push("lf_scroll");
        tick(); push("lf_c1");
        tick();
        exp_cells[12] = 8'h59;
        for (int k = 13; k < 24; k++) exp_cells[k] = 8'h20;
        push("lf_c2");
        tick();
        exp_cells[24] = 8'h20; exp_rdy = 1'b1; exp_busy = 1'b0;
        push("lf_done");
`else
        send(8'h59); exp_cells[0] = 8'h59; exp_col = 4'd1; push("y_wrap");
        send(8'h0A); exp_row = 2'd1; exp_col = 4'd0; push("lf_r1");
        send(8'h0A); exp_row = 2'd2; push("lf_r2");
        send(8'h0A); exp_row = 2'd0; push("lf_wrap");
`endif

        // A, BS, BS
        do_reset("rst_bs");
        send(8'h41); exp_cells[0] = 8'h41; exp_col = 4'd1; push("bs_a");
        send(8'h08); exp_cells[0] = 8'h20; exp_col = 4'd0; push("bs_1");
        send(8'h08); push("bs_col0");

        // direct fill then FF
        do_reset("rst_ff");
        for (int i = 0; i < 36; i++) begin
            dwrite(6'(i), 8'h30);
            exp_cells[i] = 8'h30;
            push("dw_fill");
        end
        send(8'h31); exp_cells[0] = 8'h31; exp_col = 4'd1; push("ff_pre");
        send(8'h0C);
        exp_col = 4'd0; exp_rdy = 1'b0; exp_busy = 1'b1;
        push("ff_accept");
        dw_en = 1'b1; dw_addr = 6'd5; dw_data = 8'h77;
        tick();
        for (int k = 0; k < 12; k++) exp_cells[k] = 8'h20;
        push("clr_c1");
        tick();
        for (int k = 12; k < 24; k++) exp_cells[k] = 8'h20;
        push("clr_c2");
        tick();
        dw_en = 1'b0;
        for (int k = 24; k < 36; k++) exp_cells[k] = 8'h20;
        exp_rdy = 1'b1; exp_busy = 1'b0;
        push("clr_done");

        // collisions and address bounds
        do_reset("rst_coll");
        in_valid = 1'b1; in_char = 8'h51;
        dw_en = 1'b1; dw_addr = 6'd0; dw_data = 8'h5A;
        tick();
        in_valid = 1'b0; dw_en = 1'b0;
        exp_cells[0] = 8'h51; exp_col = 4'd1;
        push("same_cell");
        in_valid = 1'b1; in_char = 8'h52;
        dw_en = 1'b1; dw_addr = 6'd7; dw_data = 8'h5A;
        tick();
        in_valid = 1'b0; dw_en = 1'b0;
        exp_cells[1] = 8'h52; exp_cells[7] = 8'h5A; exp_col = 4'd2;
        push("diff_cell");
        dwrite(6'd40, 8'h66); push("dw_addr40");
        dwrite(6'd35, 8'h66); exp_cells[35] = 8'h66; push("dw_addr35");
        dwrite(6'd36, 8'h66); push("dw_addr36");

        // reset aborts CLEAR
        send(8'h0C);
        exp_col = 4'd0; exp_rdy = 1'b0; exp_busy = 1'b1;
        push("ff2_accept");
        tick();
        exp_cells[0] = 8'h20; exp_cells[1] = 8'h20; exp_cells[7] = 8'h20;
        push("clr_part");
        do_reset("rst_mid_clear");

`ifdef VGA_CHAR_BUF_AUTOSCROLL_EN
        // reset aborts SCROLL on its 2nd cycle
        send(8'h5A); exp_cells[0] = 8'h5A; exp_col = 4'd1; push("z");
        send(8'h0A); exp_row = 2'd1; exp_col = 4'd0; push("z_lf1");
        send(8'h0A); exp_row = 2'd2; push("z_lf2");
        send(8'h0A); exp_rdy = 1'b0; exp_busy = 1'b1; push("z_lf3");
        tick(); exp_cells[0] = 8'h20; push("z_scroll_c1");
        do_reset("rst_mid_scroll");
`endif

        repeat (2) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d pending, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
